// File: rtl/ninjin_loader_pkg.sv
// ninjin image loader shared types: FSM state, AXI constants, clogb2.
// Imported by the loader top and its burst calculator.
package ninjin_loader_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_DONE
    } state_t;

    localparam logic [1:0] BURST_INCR    = 2'b01;
    localparam logic [3:0] CACHE_DEFAULT = 4'b0010;

    // ceil(log2(value)); clogb2(1) == 0
    function automatic int clogb2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/ninjin_loader_burst_calc.sv
// ninjin image loader burst sizing: arlen and the address after this burst.
// Ports: remaining, cur_addr in; len (beats-1), next_addr out.
module ninjin_loader_burst_calc
    import ninjin_loader_pkg::*;
#(
    parameter int BURST_LEN = 16,
    parameter int DWIDTH    = 32,
    parameter int LEN_WIDTH = 16
) (
    input  logic [LEN_WIDTH-1:0] remaining,
    input  logic [DWIDTH-1:0]    cur_addr,
    output logic [7:0]           len,
    output logic [DWIDTH-1:0]    next_addr
);

    localparam int BSHIFT = clogb2(DWIDTH / 8);
    localparam logic [LEN_WIDTH:0] BL = (LEN_WIDTH + 1)'(BURST_LEN);

    logic [8:0] beats;

    always_comb begin
        if ({1'b0, remaining} >= BL) begin
            len = 8'(BURST_LEN - 1);
        end else begin
            len = 8'(remaining - LEN_WIDTH'(1));
        end
        beats     = {1'b0, len} + 9'd1;
        next_addr = cur_addr + (DWIDTH'(beats) << BSHIFT);
    end

endmodule

// File: rtl/ninjin_image_loader.sv
// ninjin image loader: AXI4 read master copying DDR words into image RAM.
// Ports: clk/xrst, req/ddr_base/mem_base/total_len, ack/err, AXI AR+R, mem_we/addr/wdata.
// Optional NINJIN_LOADER_PERF_EN adds perf_cycles (req edge to ack cycle count).
module ninjin_image_loader
    import ninjin_loader_pkg::*;
#(
    parameter int BURST_LEN  = 16,
    parameter int DWIDTH     = 32,
    parameter int ID_WIDTH   = 12,
    parameter int MEM_AWIDTH = 12,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  xrst,
`ifdef NINJIN_LOADER_PERF_EN
    output logic [31:0]           perf_cycles,
`endif
    input  logic                  req,
    input  logic [DWIDTH-1:0]     ddr_base,
    input  logic [MEM_AWIDTH-1:0] mem_base,
    input  logic [LEN_WIDTH-1:0]  total_len,
    output logic                  ack,
    output logic [1:0]            err,
    output logic                  arvalid,
    input  logic                  arready,
    output logic [ID_WIDTH-1:0]   arid,
    output logic [DWIDTH-1:0]     araddr,
    output logic [7:0]            arlen,
    output logic [2:0]            arsize,
    output logic [1:0]            arburst,
    output logic                  arlock,
    output logic [3:0]            arcache,
    output logic [2:0]            arprot,
    output logic [3:0]            arqos,
    input  logic                  rvalid,
    output logic                  rready,
    input  logic [ID_WIDTH-1:0]   rid,
    input  logic [DWIDTH-1:0]     rdata,
    input  logic [1:0]            rresp,
    input  logic                  rlast,
    output logic                  mem_we,
    output logic [MEM_AWIDTH-1:0] mem_addr,
    output logic [DWIDTH-1:0]     mem_wdata
);

    state_t                  state;
    logic                    r_req;
    logic                    req_pulse;
    logic [DWIDTH-1:0]       cur_addr;
    logic [LEN_WIDTH-1:0]    remaining;
    logic [8:0]              beat_cnt;
    logic [MEM_AWIDTH-1:0]   mem_ptr;
    logic [7:0]              calc_len;
    logic [DWIDTH-1:0]       calc_next;
    logic                    beat;
    logic                    last_beat;
    logic                    unused_rid;

    assign req_pulse  = req & ~r_req;
    assign beat       = rvalid & rready;
    assign last_beat  = (beat_cnt == 9'd1);
    assign unused_rid = ^rid;

    assign arid    = '0;
    assign arsize  = 3'(clogb2(DWIDTH / 8));
    assign arburst = BURST_INCR;
    assign arlock  = 1'b0;
    assign arcache = CACHE_DEFAULT;
    assign arprot  = 3'b000;
    assign arqos   = 4'b0000;

    ninjin_loader_burst_calc #(
        .BURST_LEN (BURST_LEN),
        .DWIDTH    (DWIDTH),
        .LEN_WIDTH (LEN_WIDTH)
    ) u_calc (
        .remaining (remaining),
        .cur_addr  (cur_addr),
        .len       (calc_len),
        .next_addr (calc_next)
    );

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            state     <= S_IDLE;
            r_req     <= 1'b0;
            arvalid   <= 1'b0;
            rready    <= 1'b0;
            mem_we    <= 1'b0;
            ack       <= 1'b0;
            err       <= 2'b00;
            araddr    <= '0;
            arlen     <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cur_addr  <= '0;
            remaining <= '0;
            beat_cnt  <= '0;
            mem_ptr   <= '0;
        end else begin
            r_req  <= req;
            mem_we <= 1'b0;
            if (req_pulse) begin
                ack       <= 1'b0;
                err       <= 2'b00;
                cur_addr  <= ddr_base;
                mem_ptr   <= mem_base;
                remaining <= total_len;
                arvalid   <= 1'b0;
                rready    <= 1'b0;
                state     <= (total_len == '0) ? S_DONE : S_ADDR;
            end else begin
                case (state)
                    S_IDLE: ;
                    S_ADDR: begin
                        // AR fields are loaded once and then frozen
                        // until the slave takes them.
                        if (!arvalid) begin
                            arvalid <= 1'b1;
                            araddr  <= cur_addr;
                            arlen   <= calc_len;
                        end else if (arready) begin
                            arvalid  <= 1'b0;
                            rready   <= 1'b1;
                            cur_addr <= calc_next;
                            beat_cnt <= {1'b0, arlen} + 9'd1;
                            state    <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        if (beat) begin
                            mem_we    <= 1'b1;
                            mem_addr  <= mem_ptr;
                            mem_wdata <= rdata;
                            mem_ptr   <= mem_ptr + 1'b1;
                            remaining <= remaining - 1'b1;
                            beat_cnt  <= beat_cnt - 1'b1;
                            if (rresp[1]) err[0] <= 1'b1;
                            // Counter ends the burst; rlast is only audited.
                            if (rlast != last_beat) err[1] <= 1'b1;
                            if (last_beat) begin
                                rready <= 1'b0;
                                state  <= (remaining == LEN_WIDTH'(1))
                                          ? S_DONE : S_ADDR;
                            end
                        end
                    end
                    S_DONE: begin
                        ack   <= 1'b1;
                        state <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

`ifdef NINJIN_LOADER_PERF_EN
    logic perf_run;

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            perf_cycles <= '0;
            perf_run    <= 1'b0;
        end else if (req_pulse) begin
            perf_cycles <= '0;
            perf_run    <= 1'b1;
        end else if (perf_run) begin
            if (perf_cycles != '1) perf_cycles <= perf_cycles + 32'd1;
            if (state == S_DONE) perf_run <= 1'b0;
        end
    end
`endif

endmodule

// File: doc/ninjin_image_loader.md
Name: ninjin_image_loader

Overview:
AXI4 read-only master that fetches an input image from DDR and writes it into the on-chip image memory feeding the ninjin compute core.
Upstream is the same DDR/PS region the DDR test master exercises. Downstream is the local image RAM write port, one word per cycle.
Triggered by a req edge from the ninjin control registers; reports ack/err.

Parameters:
BURST_LEN, 16, max beats per AR burst (1..256, power of two)
DWIDTH, 32, AXI data/address width in bits
ID_WIDTH, 12, AXI ID width
MEM_AWIDTH, 12, on-chip image memory word-address width
LEN_WIDTH, 16, width of total transfer length (words)

Ports:
clk  in  1  clock
xrst  in  1  async reset, active low
req  in  1  start request, rising edge triggers a load
ddr_base  in  DWIDTH  DDR byte address of image; aligned to BURST_LEN*DWIDTH/8
mem_base  in  MEM_AWIDTH  first on-chip word address to write
total_len  in  LEN_WIDTH  number of DWIDTH words to load
ack  out  1  load finished; level, held until next req edge
err  out  2  sticky: [0] SLVERR/DECERR seen on rresp, [1] rlast position mismatch
arvalid/arready  out/in  1  AR handshake
arid  out  ID_WIDTH  constant 0
araddr  out  DWIDTH  burst byte address
arlen  out  8  beats-1 of current burst
arsize  out  3  clog2(DWIDTH/8)
arburst/arlock/arcache/arprot/arqos  out  2/1/4/3/4  INCR, 0, 4'b0010, 0, 0
rvalid/rready  in/out  1  R handshake
rid  in  ID_WIDTH  ignored
rdata  in  DWIDTH  read data
rresp  in  2  read response
rlast  in  1  last beat of burst
mem_we  out  1  image memory write enable
mem_addr  out  MEM_AWIDTH  image memory word address
mem_wdata  out  DWIDTH  image memory write data

Behaviour:
- Reset (xrst low, async): state S_IDLE; arvalid, rready, mem_we, ack = 0; err = 0; araddr, arlen, mem_addr, mem_wdata = 0.
- req_pulse = req & ~r_req. r_req is registered; it resets to 0.
- req_pulse is honoured in any state. It clears ack and err, latches ddr_base/mem_base/total_len, drops arvalid/rready and enters S_ADDR. If total_len==0 it enters S_DONE instead.
- States:
  - S_IDLE: wait for req_pulse.
  - S_ADDR: arvalid=1, araddr=current addr, arlen=min(remaining,BURST_LEN)-1. On arvalid&arready -> S_DATA. araddr advances by (arlen+1)*DWIDTH/8.
  - S_DATA: rready=1. Each rvalid&rready beat decrements remaining and beat counter.
    - On final beat of burst: if remaining becomes 0 -> S_DONE, else -> S_ADDR.
  - S_DONE: ack<=1 next cycle, -> S_IDLE.
- Only one burst is outstanding at a time. arvalid is held until arready and never drops without a handshake. AR outputs are stable while arvalid.
- Memory write latency is 1 cycle. A beat accepted at cycle N gives mem_we=1 at N+1, with mem_wdata=rdata and mem_addr=mem_base+beat index.
- mem_addr wraps modulo 2^MEM_AWIDTH.
- The memory always accepts; there is no backpressure on the mem side.
- rlast check: err[1] sets if rlast is high on a non-final beat or low on the final beat. Burst termination is counter-driven, not rlast-driven.
- err[0] sets on any accepted beat with rresp[1]=1. The data is still written.
- Last burst may be partial (total_len not a multiple of BURST_LEN).
- Reset mid-burst abandons the transaction; the AXI slave must be reset with it.

Optional Feature:
Macro NINJIN_LOADER_PERF_EN.
- Defined: adds output perf_cycles [31:0], which counts clk cycles from req_pulse to ack rising and saturates at 2^32-1. It is cleared on req_pulse, holds after ack, and resets to 0.
- Undefined: port and counter absent; all other behaviour is identical.

Decomposition:
Package ninjin_loader_pkg holds:
- state enum {S_IDLE, S_ADDR, S_DATA, S_DONE};
- AXI constants: BURST_INCR=2'b01, CACHE_DEFAULT=4'b0010;
- clogb2 function (shared with ninjin.svh users).

One sub-module, ninjin_loader_burst_calc: a combinational next-arlen/next-araddr computation from remaining count and current address. The FSM stays in the top module.

Test Plan:
- total_len=32, BURST_LEN=16, ddr_base=0x1000, mem_base=0, slave returns rdata=index -> 2 ARs at 0x1000/0x1040 with arlen=15; mem_addr 0..31 gets data 0..31; ack=1; err=0.
- total_len=20 -> ARs with arlen=15 then arlen=3; 20 mem writes; ack after final write.
- Slave inserts random rvalid gaps and arready delay of 5 cycles -> arvalid held stable for 5 cycles; no lost or duplicated writes.
- Beat 7 has rresp=2'b10 -> err=2'b01, data still written; rlast early on beat 14 of 16 -> err[1]=1.
- total_len=0 -> no AR issued; ack=1 two cycles after req edge.
- req re-pulsed mid-burst -> ack/err cleared; new load starts from the newly latched ddr_base. Separately, assert xrst mid-S_DATA -> all outputs return to their reset values immediately.
